// File: rtl/adc_pkg.sv
// Shared definitions for the ADC channel averager: data width, channel codes
// and the tagged FIFO entry layout.
package adc_pkg;

  localparam int ADC_DATA_W = 24;

  // Channel tags carried alongside every averaged result
  localparam logic ADC_CH1 = 1'b0;
  localparam logic ADC_CH2 = 1'b1;

  // One FIFO entry: channel tag in the MSB, averaged sample below it
  typedef struct packed {
    logic                  ch;
    logic [ADC_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/adc_tag_fifo.sv
// Synchronous FIFO for tagged averaging results.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push into a full FIFO is dropped unless a pop happens in the same cycle;
// a dropped push raises a sticky overflow flag that only clear or reset lowers.
module adc_tag_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic             overflow
);

  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             pop_eff;
  logic             push_eff;
  logic             mem_we;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level    = wr_ptr_q - rd_ptr_q;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = ovf_q;

  // Pointer and overflow next-state; clear overrides any push or pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    pop_eff  = pop & ~empty;
    push_eff = push & (~full | pop_eff);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_eff) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_INC;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_eff) begin
        rd_ptr_d = rd_ptr_q + PTR_INC;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push & ~push_eff) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // Pointer and sticky overflow registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; zeroed on reset so the head reads 0 before the first push
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/adc_chan_avg.sv
// Two-channel block averager for the ADC sample stream.
// Each channel accumulates 2**AVG_LOG2 samples, then pushes the floored mean,
// tagged with its channel, into adc_tag_fifo behind a valid/ready port.
// Optional feature macro ADC_AVG_OFFSET_EN: adds per-channel offset inputs that
// are subtracted (with saturation) from each mean before it is pushed.
module adc_chan_avg
  import adc_pkg::*;
#(
  parameter int DATA_W     = ADC_DATA_W,
  parameter int AVG_LOG2   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_channel,
  input  logic              in_valid,
  input  logic              clear,
`ifdef ADC_AVG_OFFSET_EN
  input  logic [DATA_W-1:0] offset_ch1,
  input  logic [DATA_W-1:0] offset_ch2,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              out_channel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [LVL_W-1:0]  level
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] CNT_LAST = {AVG_LOG2{1'b1}};
  localparam logic [AVG_LOG2-1:0] CNT_INC  = {{(AVG_LOG2-1){1'b0}}, 1'b1};

  logic signed [ACC_W-1:0]    acc_q [2];
  logic signed [ACC_W-1:0]    acc_d [2];
  logic        [AVG_LOG2-1:0] cnt_q [2];
  logic        [AVG_LOG2-1:0] cnt_d [2];

  logic signed [ACC_W-1:0]    sample_ext;
  logic signed [ACC_W-1:0]    sum;
  logic        [DATA_W-1:0]   result;
  logic        [DATA_W-1:0]   push_val;
  logic                       push;
  fifo_entry_t                push_entry;
  fifo_entry_t                pop_entry;
  logic                       fifo_full;
  logic                       fifo_empty;

`ifdef ADC_AVG_OFFSET_EN
  // a - b clamped to the signed DATA_W range
  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] diff;
    diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    if (diff[DATA_W] != diff[DATA_W-1]) begin
      if (diff[DATA_W]) begin
        sat_sub = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        sat_sub = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end else begin
      sat_sub = diff[DATA_W-1:0];
    end
  endfunction
`endif

  // Sign-extended sample, running sum and floored mean for the sampled channel
  always_comb begin
    sample_ext = {{AVG_LOG2{in_data[DATA_W-1]}}, in_data};
    sum        = acc_q[in_channel] + sample_ext;
    result     = DATA_W'(sum >>> AVG_LOG2);
`ifdef ADC_AVG_OFFSET_EN
    if (in_channel == ADC_CH2) begin
      push_val = sat_sub(result, offset_ch2);
    end else begin
      push_val = sat_sub(result, offset_ch1);
    end
`else
    push_val = result;
`endif
    push_entry.ch   = in_channel;
    push_entry.data = push_val;
  end

  // Accumulator/counter next-state and FIFO push; clear wins over a sample
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (clear) begin
      acc_d[0] = '0;
      acc_d[1] = '0;
      cnt_d[0] = '0;
      cnt_d[1] = '0;
    end else if (in_valid) begin
      if (cnt_q[in_channel] == CNT_LAST) begin
        // Block complete: push the mean and restart, even if the FIFO drops it
        push              = 1'b1;
        acc_d[in_channel] = '0;
        cnt_d[in_channel] = '0;
      end else begin
        acc_d[in_channel] = sum;
        cnt_d[in_channel] = cnt_q[in_channel] + CNT_INC;
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Per-channel accumulator and sample-count registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      acc_q[0] <= '0;
      acc_q[1] <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  adc_tag_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .clear     (clear),
    .push      (push),
    .push_data (push_entry),
    .pop       (out_ready),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level),
    .overflow  (overflow)
  );

  assign out_valid   = ~fifo_empty;
  assign out_data    = pop_entry.data;
  assign out_channel = pop_entry.ch;

endmodule

// File: tb/tb_adc_chan_avg.sv
// Directed bench for adc_chan_avg with AVG_LOG2 = 2 (4-sample means) and a
// 4-entry FIFO. Inputs change on the falling edge and outputs are sampled there.
module tb_adc_chan_avg;
  import adc_pkg::*;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_channel = 1'b0;
  logic          in_valid = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_channel;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          overflow;
  logic [2:0]    level;
`ifdef ADC_AVG_OFFSET_EN
  logic [DW-1:0] offset_ch1 = '0;
  logic [DW-1:0] offset_ch2 = '0;
`endif

  int errors = 0;
  int checks = 0;

  adc_chan_avg #(.DATA_W(DW), .AVG_LOG2(2), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .in_data     (in_data),
    .in_channel  (in_channel),
    .in_valid    (in_valid),
    .clear       (clear),
`ifdef ADC_AVG_OFFSET_EN
    .offset_ch1  (offset_ch1),
    .offset_ch2  (offset_ch2),
`endif
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .level       (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ch;
    logic [DW-1:0] s0, s1, s2, s3;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge
  task automatic send(input logic ch, input logic [DW-1:0] d);
    in_valid   = 1'b1;
    in_channel = ch;
    in_data    = d;
    @(negedge clk);
    in_valid   = 1'b0;
  endtask

  task automatic send4(input logic ch, input logic [DW-1:0] d);
    for (int k = 0; k < 4; k++) send(ch, d);
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    vecs[0] = '{ADC_CH1, 24'd4,        24'd8,        24'd12,       24'd16,       24'h00000A};
    vecs[1] = '{ADC_CH2, 24'hFFFFFF,   24'hFFFFFE,   24'hFFFFFD,   24'hFFFFFC,   24'hFFFFFD};
    vecs[2] = '{ADC_CH1, 24'd1,        24'd2,        24'd3,        24'd3,        24'd2};
    vecs[3] = '{ADC_CH2, 24'hFFFFFF,   24'd0,        24'd0,        24'd0,        24'hFFFFFF};
    vecs[4] = '{ADC_CH1, 24'h7FFFFF,   24'h7FFFFF,   24'h7FFFFF,   24'h7FFFFF,   24'h7FFFFF};
    vecs[5] = '{ADC_CH2, 24'h800000,   24'h800000,   24'h800000,   24'h800000,   24'h800000};
    vecs[6] = '{ADC_CH2, 24'd6,        24'd6,        24'd6,        24'hFFFFFD,   24'd3};

    // Reset values, checked while reset is still asserted
    #3;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {8'd0, out_data}, 32'd0);
    chk("rst_chan", {31'd0, out_channel}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    // Table-driven single-channel averages
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].ch, vecs[i].s0);
      send(vecs[i].ch, vecs[i].s1);
      send(vecs[i].ch, vecs[i].s2);
      chk($sformatf("v%0d_early", i), {31'd0, out_valid}, 32'd0);
      send(vecs[i].ch, vecs[i].s3);
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_data", i), {8'd0, out_data}, {8'd0, vecs[i].exp});
      chk($sformatf("v%0d_chan", i), {31'd0, out_channel}, {31'd0, vecs[i].ch});
      chk($sformatf("v%0d_level", i), {29'd0, level}, 32'd1);
      pop1();
      chk($sformatf("v%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end

    // Interleaved channels: ch1 completes first
    for (int k = 0; k < 4; k++) begin
      send(ADC_CH1, 24'd100);
      send(ADC_CH2, 24'hFFFF9C);
    end
    chk("il_level", {29'd0, level}, 32'd2);
    chk("il_data0", {8'd0, out_data}, 32'd100);
    chk("il_chan0", {31'd0, out_channel}, 32'd0);
    pop1();
    chk("il_data1", {8'd0, out_data}, 32'h00FFFF9C);
    chk("il_chan1", {31'd0, out_channel}, 32'd1);
    pop1();
    chk("il_empty", {31'd0, out_valid}, 32'd0);

    // Five results with no consumer: fifth is dropped
    for (int v = 1; v <= 5; v++) send4(ADC_CH1, DW'(v));
    chk("of_level", {29'd0, level}, 32'd4);
    chk("of_ovf", {31'd0, overflow}, 32'd1);
    chk("of_stall", {8'd0, out_data}, 32'd1);
    for (int v = 1; v <= 4; v++) begin
      chk($sformatf("of_drain%0d", v), {8'd0, out_data}, v);
      pop1();
    end
    chk("of_empty", {31'd0, out_valid}, 32'd0);
    chk("of_sticky", {31'd0, overflow}, 32'd1);
    clr();
    chk("of_clr", {31'd0, overflow}, 32'd0);

    // Full FIFO with push and pop on the same edge
    for (int v = 10; v <= 13; v++) send4(ADC_CH1, DW'(v));
    chk("pp_full", {29'd0, level}, 32'd4);
    send(ADC_CH1, 24'd20);
    send(ADC_CH1, 24'd20);
    send(ADC_CH1, 24'd20);
    out_ready = 1'b1;
    send(ADC_CH1, 24'd20);
    out_ready = 1'b0;
    chk("pp_level", {29'd0, level}, 32'd4);
    chk("pp_ovf", {31'd0, overflow}, 32'd0);
    chk("pp_head", {8'd0, out_data}, 32'd11);
    pop1(); pop1(); pop1();
    chk("pp_last", {8'd0, out_data}, 32'd20);
    pop1();
    chk("pp_empty", {31'd0, out_valid}, 32'd0);

    // Clear flushes the FIFO and partial sums, and beats a same-cycle sample
    send4(ADC_CH2, 24'd8);
    send(ADC_CH1, 24'd100);
    send(ADC_CH1, 24'd100);
    clear      = 1'b1;
    in_valid   = 1'b1;
    in_channel = ADC_CH1;
    in_data    = 24'd999;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("cl_valid", {31'd0, out_valid}, 32'd0);
    chk("cl_level", {29'd0, level}, 32'd0);
    chk("cl_ovf", {31'd0, overflow}, 32'd0);
    send4(ADC_CH1, 24'd4);
    chk("cl_data", {8'd0, out_data}, 32'd4);
    chk("cl_level1", {29'd0, level}, 32'd1);
    pop1();

    // Reset mid-average discards the partial sum
    send(ADC_CH1, 24'd1000);
    send(ADC_CH1, 24'd1000);
    rst_l = 1'b0;
    #2;
    chk("ra_level", {29'd0, level}, 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    send4(ADC_CH1, 24'd8);
    chk("ra_data", {8'd0, out_data}, 32'd8);
    pop1();

`ifdef ADC_AVG_OFFSET_EN
    // Offset subtraction and saturation
    offset_ch1 = 24'd5;
    send4(ADC_CH1, 24'd10);
    chk("off_data", {8'd0, out_data}, 32'd5);
    pop1();
    offset_ch1 = 24'd100;
    send4(ADC_CH1, 24'h800008);
    chk("off_sat", {8'd0, out_data}, 32'h00800000);
    pop1();
    offset_ch1 = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
